// File: rtl/hash_des_sbox_iter_if.sv
// Streaming port bundle for hash_des_sbox_iter: message input, digest output and status.
// The abort input exists only when HASH_ITER_ABORT_EN is defined.
interface hash_des_sbox_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic [63:0] in_len;
    logic [31:0] digest;
    logic        digest_valid;
    logic        digest_ready;
    logic        busy;
`ifdef HASH_ITER_ABORT_EN
    logic        abort;

    modport master (
        output in_valid, in_byte, in_len, digest_ready, abort,
        input  in_ready, digest, digest_valid, busy
    );
    modport slave (
        input  in_valid, in_byte, in_len, digest_ready, abort,
        output in_ready, digest, digest_valid, busy
    );
`else
    modport master (
        output in_valid, in_byte, in_len, digest_ready,
        input  in_ready, digest, digest_valid, busy
    );
    modport slave (
        input  in_valid, in_byte, in_len, digest_ready,
        output in_ready, digest, digest_valid, busy
    );
`endif
endinterface

// File: rtl/hash_des_sbox_iter.sv
// Iterated nibble hash on DES S-box S5: ROUNDS rounds per message byte, then a length-mixing
// finalisation round. Define HASH_ITER_ABORT_EN to add a synchronous abort input.
module hash_des_sbox_iter #(
    parameter int unsigned ROUNDS = 4,
    parameter logic [31:0] IV     = 32'h4B71DF03
) (
    input logic                 clk,
    input logic                 rst_n,
    hash_des_sbox_iter_if.slave bus
);

    if (ROUNDS < 1 || ROUNDS > 15) begin : g_rounds_check
        $error("hash_des_sbox_iter: ROUNDS must be in 1..15");
    end

    typedef enum logic [2:0] {StIdle, StRound, StWaitByte, StFinal, StOut} state_e;

    // S5 flattened by index {row, column}, one nibble per entry, row 0 in the low bits.
    localparam logic [255:0] S5 = {64'h354A90F6D2E17C8B, 64'hE0365C9F87DAB124,
                                   64'h6893AF051D74C2BE, 64'h9E0DF3586BA714C2};

    function automatic logic [3:0] sbox(input logic [5:0] x);
        logic [5:0] idx;
        idx = {x[5], x[0], x[4:1]};
        return S5[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] rotl4(input logic [3:0] n, input logic [1:0] k);
        logic [7:0] t;
        t = {n, n} << k;
        return t[7:4];
    endfunction

    // Output nibble i takes input nibble i+1, xors its own key nibble, rotates by i/2.
    function automatic logic [31:0] mix(input logic [31:0] h, input logic [31:0] key);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = rotl4(h[4*((i+1)%8) +: 4] ^ key[4*i +: 4], 2'(i / 2));
        end
        return r;
    endfunction

    function automatic logic [31:0] round_key(input logic [7:0] b);
        return {8{sbox({b[3] ^ b[2], b[1], b[0], b[7], b[6], b[5] ^ b[4]})}};
    endfunction

    function automatic logic [31:0] final_key(input logic [63:0] len);
        logic [31:0] k;
        logic [7:0]  c;
        k = '0;
        for (int i = 0; i < 8; i++) begin
            c = len[8*i +: 8];
            k[4*i +: 4] = sbox({c[7] ^ c[1], c[3], c[2], c[5] ^ c[0], c[4], c[6]});
        end
        return k;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] h_q, h_d;
    logic [63:0] rem_q, rem_d;
    logic [63:0] len_q, len_d;
    logic [7:0]  byte_q, byte_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] digest_q, digest_d;
    logic        dvalid_q, dvalid_d;
    logic        in_ready;
    logic        hs;

    // in_ready is gated by rst_n so it reads 0 for the whole reset assertion.
    assign in_ready         = rst_n && (state_q == StIdle || state_q == StWaitByte);
    assign hs               = bus.in_valid && in_ready;
    assign bus.in_ready     = in_ready;
    assign bus.digest       = digest_q;
    assign bus.digest_valid = dvalid_q;
    assign bus.busy         = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            h_q      <= IV;
            rem_q    <= '0;
            len_q    <= '0;
            byte_q   <= '0;
            cnt_q    <= '0;
            digest_q <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            rem_q    <= rem_d;
            len_q    <= len_d;
            byte_q   <= byte_d;
            cnt_q    <= cnt_d;
            digest_q <= digest_d;
            dvalid_q <= dvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        rem_d    = rem_q;
        len_d    = len_q;
        byte_d   = byte_q;
        cnt_d    = cnt_q;
        digest_d = digest_q;
        dvalid_d = dvalid_q;
        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    h_d   = IV;
                    len_d = bus.in_len;
                    cnt_d = '0;
                    if (bus.in_len != '0) begin
                        rem_d   = bus.in_len - 64'd1;
                        byte_d  = bus.in_byte;
                        state_d = StRound;
                    end else begin
                        state_d = StFinal;
                    end
                end
            end
            StRound: begin
                h_d = mix(h_q, round_key(byte_q));
                if (cnt_q == 4'(ROUNDS - 1)) begin
                    cnt_d   = '0;
                    state_d = (rem_q != '0) ? StWaitByte : StFinal;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StWaitByte: begin
                if (hs) begin
                    byte_d  = bus.in_byte;
                    rem_d   = rem_q - 64'd1;
                    state_d = StRound;
                end
            end
            StFinal: begin
                h_d      = mix(h_q, final_key(len_q));
                digest_d = h_d;
                dvalid_d = 1'b1;
                state_d  = StOut;
            end
            StOut: begin
                if (dvalid_q && bus.digest_ready) begin
                    dvalid_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef HASH_ITER_ABORT_EN
        // Abort wins over any same-cycle handshake; the last digest stays readable.
        if (bus.abort) begin
            state_d  = StIdle;
            h_d      = h_q;
            rem_d    = '0;
            len_d    = len_q;
            byte_d   = byte_q;
            cnt_d    = '0;
            digest_d = digest_q;
            dvalid_d = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_hash_des_sbox_iter.sv
// Randomized self-checking bench for hash_des_sbox_iter with ROUNDS = 4, 1 and 15 instances,
// checked against an arithmetic reference model of the hash.
module tb_hash_des_sbox_iter;

    localparam logic [31:0] IV = 32'h4B71DF03;
    localparam int RND [3] = '{4, 1, 15};
    localparam int GAPS [3] = '{0, 3, 7};
    localparam int S5T [4][16] = '{
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9},
        '{14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6},
        '{ 4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14},
        '{11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3}};

    typedef logic [7:0] msg_t [$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        in_valid     [3];
    logic        in_ready     [3];
    logic [7:0]  in_byte      [3];
    logic [63:0] in_len       [3];
    logic [31:0] digest       [3];
    logic        digest_valid [3];
    logic        digest_ready [3];
    logic        busy         [3];

    hash_des_sbox_iter_if b0 ();
    hash_des_sbox_iter_if b1 ();
    hash_des_sbox_iter_if b2 ();

`define TB_HOOK(N, B) \
    assign B.in_valid     = in_valid[N]; \
    assign B.in_byte      = in_byte[N]; \
    assign B.in_len       = in_len[N]; \
    assign B.digest_ready = digest_ready[N]; \
    assign in_ready[N]     = B.in_ready; \
    assign digest[N]       = B.digest; \
    assign digest_valid[N] = B.digest_valid; \
    assign busy[N]         = B.busy;

    `TB_HOOK(0, b0)
    `TB_HOOK(1, b1)
    `TB_HOOK(2, b2)

`ifdef HASH_ITER_ABORT_EN
    logic abort [3];
    assign b0.abort = abort[0];
    assign b1.abort = abort[1];
    assign b2.abort = abort[2];
`endif

    hash_des_sbox_iter #(.ROUNDS(4))  u_dut_r4  (.clk(clk), .rst_n(rst_n), .bus(b0));
    hash_des_sbox_iter #(.ROUNDS(1))  u_dut_r1  (.clk(clk), .rst_n(rst_n), .bus(b1));
    hash_des_sbox_iter #(.ROUNDS(15)) u_dut_r15 (.clk(clk), .rst_n(rst_n), .bus(b2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int sbox_ref(input int x);
        return S5T[((x >> 5) & 1) * 2 + (x & 1)][(x >> 1) & 15];
    endfunction

    function automatic int rotl_ref(input int n, input int k);
        return ((n << k) | (n >> (4 - k))) & 15;
    endfunction

    function automatic logic [31:0] ref_hash(input int rounds, input msg_t msg);
        int h [8];
        int t [8];
        int b, m, c, sv;
        logic [63:0] len;
        logic [31:0] res;
        len = 64'(msg.size());
        for (int i = 0; i < 8; i++) h[i] = int'((IV >> (4 * i)) & 32'hF);
        foreach (msg[k]) begin
            b  = int'(msg[k]);
            m  = ((((b >> 3) ^ (b >> 2)) & 1) << 5) | (((b >> 1) & 1) << 4) | ((b & 1) << 3)
               | (((b >> 7) & 1) << 2) | (((b >> 6) & 1) << 1) | (((b >> 5) ^ (b >> 4)) & 1);
            sv = sbox_ref(m);
            for (int r = 0; r < rounds; r++) begin
                for (int i = 0; i < 8; i++) t[i] = rotl_ref(h[(i + 1) % 8] ^ sv, i / 2);
                h = t;
            end
        end
        for (int i = 0; i < 8; i++) begin
            c = int'((len >> (8 * i)) & 64'hFF);
            m = ((((c >> 7) ^ (c >> 1)) & 1) << 5) | (((c >> 3) & 1) << 4) | (((c >> 2) & 1) << 3)
              | ((((c >> 5) ^ c) & 1) << 2) | (((c >> 4) & 1) << 1) | ((c >> 6) & 1);
            t[i] = rotl_ref(h[(i + 1) % 8] ^ sbox_ref(m), i / 2);
        end
        res = '0;
        for (int i = 0; i < 8; i++) res = res | (32'(t[i]) << (4 * i));
        return res;
    endfunction

    function automatic msg_t rand_msg(input int n);
        msg_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic wait_ready(input int d);
        int n = 0;
        while (!in_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[d]) check("ready_timeout", 64'(in_ready[d]), 64'd1);
    endtask

    // Returns at the negedge just after the handshake edge.
    task automatic push(input int d, input logic [7:0] b, input logic [63:0] len);
        in_valid[d] = 1'b1;
        in_byte[d]  = b;
        in_len[d]   = len;
        wait_ready(d);
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_byte[d]  = 8'($urandom);
        in_len[d]   = {$urandom, $urandom};
    endtask

    task automatic run_msg(input int d, input msg_t msg, input int gap, input bit consume,
                           output logic [31:0] dig);
        logic [31:0] exp;
        int lat;
        exp = ref_hash(RND[d], msg);
        if (msg.size() == 0) begin
            push(d, 8'($urandom), 64'd0);
        end else begin
            for (int i = 0; i < msg.size(); i++) begin
                if (i > 0) begin
                    wait_ready(d);
                    repeat (gap) @(negedge clk);
                end
                push(d, msg[i], (i == 0) ? 64'(msg.size()) : {$urandom, $urandom});
            end
        end
        lat = 1;
        while (!digest_valid[d] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'((msg.size() == 0) ? 2 : RND[d] + 2));
        check("digest", 64'(digest[d]), 64'(exp));
        dig = digest[d];
        if (consume) begin
            digest_ready[d] = 1'b1;
            @(negedge clk);
            digest_ready[d] = 1'b0;
            check("valid_drop", 64'(digest_valid[d]), 64'd0);
            check("digest_kept", 64'(digest[d]), 64'(exp));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        msg_t msg;
        msg_t empty;
        logic [31:0] dig, ref0, held;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]     = 1'b0;
            in_byte[i]      = '0;
            in_len[i]       = '0;
            digest_ready[i] = 1'b0;
`ifdef HASH_ITER_ABORT_EN
            abort[i]        = 1'b0;
`endif
        end
        empty.delete();

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", 64'(in_ready[i]), 64'd0);
            check("rst_busy", 64'(busy[i]), 64'd0);
            check("rst_digest_valid", 64'(digest_valid[i]), 64'd0);
            check("rst_digest", 64'(digest[i]), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready[0]), 64'd1);

        run_msg(0, empty, 0, 1'b1, dig);
        check("zero_len_const", 64'(dig), 64'h83656FD2);
        run_msg(0, rand_msg(1), 0, 1'b1, dig);

        for (int d = 0; d < 3; d++) begin
            msg = rand_msg(3);
            for (int g = 0; g < 3; g++) begin
                run_msg(d, msg, GAPS[g], 1'b1, dig);
                if (g == 0) ref0 = dig;
                else check("gap_vs_gapfree", 64'(dig), 64'(ref0));
            end
        end

        for (int k = 0; k < 12; k++) begin
            run_msg($urandom_range(0, 2), rand_msg($urandom_range(0, 5)),
                    $urandom_range(0, 4), 1'b1, dig);
        end

        // Consumer stall in OUT while the next message is already offered.
        run_msg(0, rand_msg(2), 0, 1'b0, held);
        in_valid[0] = 1'b1;
        in_len[0]   = 64'd0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_digest", 64'(digest[0]), 64'(held));
            check("stall_valid", 64'(digest_valid[0]), 64'd1);
            check("stall_in_ready", 64'(in_ready[0]), 64'd0);
        end
        digest_ready[0] = 1'b1;
        @(negedge clk);
        digest_ready[0] = 1'b0;
        check("stall_release_valid", 64'(digest_valid[0]), 64'd0);
        check("stall_release_ready", 64'(in_ready[0]), 64'd1);
        check("stall_release_digest", 64'(digest[0]), 64'(held));
        run_msg(0, empty, 0, 1'b1, dig);

        // Maximum length must keep asking for bytes rather than finalising.
        push(1, 8'($urandom), '1);
        wait_ready(1);
        check("huge_len_wait", {61'd0, busy[1], in_ready[1], digest_valid[1]}, 64'b110);
        push(1, 8'($urandom), {$urandom, $urandom});
        wait_ready(1);
        check("huge_len_wait2", {61'd0, busy[1], in_ready[1], digest_valid[1]}, 64'b110);

        // Asynchronous reset during the rounds of byte 2.
        msg = rand_msg(3);
        push(0, msg[0], 64'd3);
        wait_ready(0);
        push(0, msg[1], {$urandom, $urandom});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_digest", 64'(digest[0]), 64'd0);
        check("async_rst_valid", 64'(digest_valid[0]), 64'd0);
        check("async_rst_busy", 64'(busy[0]), 64'd0);
        check("async_rst_ready", 64'(in_ready[0]), 64'd0);
        check("async_rst_busy_r1", 64'(busy[1]), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_msg(0, rand_msg(3), 0, 1'b1, dig);
        run_msg(1, rand_msg(2), 1, 1'b1, dig);

`ifdef HASH_ITER_ABORT_EN
        held = digest[0];
        msg  = rand_msg(3);
        push(0, msg[0], 64'd3);
        wait_ready(0);
        abort[0]    = 1'b1;
        in_valid[0] = 1'b1;
        in_byte[0]  = 8'($urandom);
        @(negedge clk);
        abort[0]    = 1'b0;
        in_valid[0] = 1'b0;
        check("abort_state", {61'd0, busy[0], digest_valid[0], in_ready[0]}, 64'b001);
        check("abort_digest_kept", 64'(digest[0]), 64'(held));
        repeat (3) @(negedge clk);
        check("abort_no_valid", 64'(digest_valid[0]), 64'd0);
        run_msg(0, msg, 0, 1'b1, dig);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hash_des_sbox_iter.md
HASH_DES_SBOX_ITER -- requirements
Module: hash_des_sbox_iter

Interface
REQ-001 SHALL have parameter ROUNDS, default 4, meaning hash rounds applied per message byte; legal range 1..15; elaboration SHALL fail outside it.
REQ-002 SHALL have parameter IV, default 32'h4B71DF03, meaning initial hash state; nibble i = bits [4i+3:4i].
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  message byte / length valid.
REQ-006 in_ready  output  1  block accepts in_byte this cycle.
REQ-007 in_byte  input  8  message byte.
REQ-008 in_len  input  64  message length in bytes; sampled on first handshake of a message only.
REQ-009 digest  output  32  hash result.
REQ-010 digest_valid  output  1  digest held valid.
REQ-011 digest_ready  input  1  consumer accepts digest.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND, WAIT_BYTE, FINAL, OUT.
REQ-014 in_ready SHALL be 1 exactly in IDLE and WAIT_BYTE; a handshake is in_valid&&in_ready.
REQ-015 IDLE handshake, in_len>0: load H=IV, REM=in_len-1, latch in_byte and in_len, go ROUND.
REQ-016 IDLE handshake, in_len==0: in_byte ignored, H=IV, go FINAL.
REQ-017 ROUND SHALL apply exactly one round per cycle for ROUNDS cycles, then go WAIT_BYTE if REM>0, else FINAL.
REQ-018 WAIT_BYTE handshake: latch in_byte, REM=REM-1, go ROUND; in_len ignored.
REQ-019 Round: H'[i] = rotl4(H[(i+1) mod 8] ^ S(M6), floor(i/2)), i=0..7.
REQ-020 M6 = {b3^b2, b1, b0, b7, b6, b5^b4} of the latched byte.
REQ-021 S() SHALL be DES S-box S5: row={x[5],x[0]}, column=x[4:1]; row 0 = 2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9.
REQ-022 FINAL (one cycle): H'[i] = rotl4(H[(i+1) mod 8] ^ S(C6(L_i)), floor(i/2)), L_i = latched in_len[8i+7:8i].
REQ-023 C6(c) = {c7^c1, c3, c2, c5^c0, c4, c6}.
REQ-024 FINAL SHALL register H' to digest, set digest_valid=1, go OUT.
REQ-025 OUT: digest and digest_valid SHALL hold stable until digest_valid&&digest_ready, then digest_valid=0, go IDLE next cycle.
REQ-026 Latency: last byte handshake to digest_valid = ROUNDS+2 cycles; zero-length = 2 cycles.
REQ-027 in_valid low in WAIT_BYTE SHALL stall indefinitely with H unchanged.
REQ-028 REM SHALL be 64-bit; in_len=2^64-1 SHALL be processed without wrap.
REQ-029 digest SHALL retain its last value after digest_valid falls.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, digest=0, digest_valid=0, busy=0, in_ready=0 while asserted, H=IV, REM=0.
REQ-031 Reset mid-message or mid-OUT SHALL discard all progress; first handshake after release starts a new message.

Configuration
REQ-032 Macro HASH_ITER_ABORT_EN: when defined, adds input abort (1 bit); abort=1 SHALL, next edge, force IDLE, digest_valid=0, REM=0, digest unchanged, overriding any same-cycle handshake.
REQ-033 Without HASH_ITER_ABORT_EN, no abort port exists; messages end only by length or reset.

Verification
REQ-034 Zero-length: in_len=0 handshake, IV default -> digest=32'h83656FD2, digest_valid 2 cycles after handshake.
REQ-035 One-byte message in_len=1, ROUNDS=4 -> digest_valid exactly 6 cycles after handshake; digest matches reference model.
REQ-036 Three-byte message with in_valid gaps of 0,3,7 cycles, ROUNDS in {1,4,15} -> digest identical to gap-free run.
REQ-037 digest_ready held low 10 cycles -> digest stable, in_ready=0, next message accepted only after OUT->IDLE.
REQ-038 rst_n pulsed during ROUND of byte 2 -> outputs zero immediately; following message digest matches fresh reference.
REQ-039 With HASH_ITER_ABORT_EN, abort and in_valid same cycle in WAIT_BYTE -> IDLE, no byte consumed, digest_valid stays 0.
